muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the ALU in the execute stage. It accepts one operation at a time from the decode/ALU control path.
- It holds the pipeline with a stall signal while it iterates a shift-add multiply or a restoring divide over DATA_WIDTH cycles.
- It presents a one-cycle done pulse with the final result for writeback muxing.

Parameters:
- DATA_WIDTH, 32, operand and result width; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request an M-extension operation; sampled only in IDLE.
- Funct3  input  3  operation select, latched on accept: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  DATA_WIDTH  rs1 operand (multiplicand/dividend), latched on accept.
- SrcB  input  DATA_WIDTH  rs2 operand (multiplier/divisor), latched on accept.
- flush  input  1  synchronous kill of the in-flight operation.
- stall  output  1  pipeline hold request.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse; Result valid this cycle.
- Result  output  DATA_WIDTH  final result; holds value until the next done.

Behaviour:
- Clock and reset:
  - Single clock domain. reset is synchronous and active-high; it has priority over flush and start.
  - Reset values: state IDLE; stall=0, busy=0, done=0, Result=0; all internal registers 0.
- States: IDLE, PREP, ITER, FIXUP, DONE.
- IDLE:
  - start=1 with flush=0 latches Funct3, SrcA and SrcB, then moves to PREP.
  - start is ignored in every other state.
- PREP (1 cycle):
  - Computes operand magnitudes. SrcA is signed for MUL/MULH/MULHSU/DIV/REM; SrcB is signed for MUL/MULH/DIV/REM.
  - Records the result sign: product sign for multiplies, quotient sign for DIV, dividend sign for REM.
  - Clears the accumulator and loads the iteration counter with DATA_WIDTH-1. Moves to ITER.
- ITER (exactly DATA_WIDTH cycles):
  - Multiply: one shift-add step per cycle into a 2*DATA_WIDTH accumulator.
  - Divide: one restoring shift-subtract step per cycle, producing quotient and remainder registers.
  - Counter decrements each cycle; moves to FIXUP when the counter is 0.
- FIXUP (1 cycle):
  - Applies two's-complement negation when the recorded sign is 1.
  - Selects the low half (MUL), high half (MULH/MULHSU/MULHU), quotient (DIV/DIVU) or remainder (REM/REMU), and writes it to Result. Moves to DONE.
- DONE (1 cycle): done=1, then returns to IDLE.
- Latency: start accepted at edge N gives done=1 in the cycle after edge N+DATA_WIDTH+2. For DATA_WIDTH=32 that is 35 cycles after accept.
- stall:
  - Combinational: stall = (state==IDLE && start) || state in {PREP, ITER, FIXUP}.
  - stall is 0 in DONE, so the pipeline advances in the same cycle the result is consumed.
- Division corner cases (RISC-V defined, forced in FIXUP, no sign correction applied):
  - Divisor 0: DIV/DIVU result is all ones; REM/REMU result is SrcA.
  - Signed overflow (SrcA = most-negative, SrcB = -1): DIV result is SrcA, REM result is 0. This falls out of the magnitude algorithm and must not be special-cased incorrectly.
- Width: multiply accumulator is 2*DATA_WIDTH bits; the divide partial remainder is DATA_WIDTH+1 bits.
- flush:
  - Any state except DONE returns to IDLE on the next edge. No done pulse; Result is unchanged.
  - flush in DONE has no effect; the pulse completes.
  - flush together with start in IDLE: the start is dropped.
- Reset mid-operation: returns to IDLE; outputs take reset values; no done pulse.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - PREP detects a zero operand: either operand 0 for multiplies, or divisor 0 for divides.
  - On detection, PREP jumps directly to FIXUP. Multiplies give result 0; divides use the divide-by-zero rules above.
  - done is asserted 3 cycles after accept.
- Undefined: no detection; every operation takes the full DATA_WIDTH+3 cycles.
- Result values are identical in both builds.

Test Plan:
- MUL, SrcA=7, SrcB=0xFFFFFFFD -> Result=0xFFFFFFEB. done exactly 35 cycles after accept; stall high from the accept cycle through FIXUP.
- MULH, SrcA=SrcB=0x80000000 -> 0x40000000. MULHU, SrcA=SrcB=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU, SrcA=0xFFFFFFFF, SrcB=2 -> 0xFFFFFFFF.
- DIV, SrcA=0xFFFFFFF9 (-7), SrcB=2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU, SrcA=100, SrcB=7 -> 14. REMU on the same operands -> 2.
- DIVU, SrcA=5, SrcB=0 -> 0xFFFFFFFF. REM, SrcA=5, SrcB=0 -> 5. DIV, SrcA=0x80000000, SrcB=0xFFFFFFFF -> 0x80000000. REM on the same operands -> 0.
- Control: flush asserted at cycle 10 of ITER -> IDLE on the next edge, no done, Result keeps its prior value. reset at cycle 20 -> all outputs 0. start asserted while busy -> ignored.
- With MULDIV_EARLY_OUT_EN: DIV, SrcB=0 -> done 3 cycles after accept, Result=0xFFFFFFFF. MUL, SrcA=0 -> done 3 cycles after accept, Result=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle sequencer for the RV32M multiply/divide instructions. It sits
// beside the ALU in the execute stage. It takes one operation at a time and
// stalls the pipeline while the operation runs. Multiplies use a shift-add
// loop and divides use a restoring shift-subtract loop. Each loop runs for
// DATA_WIDTH iterations. The final result is presented with a one-cycle done
// pulse.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset (priority over flush/start)
//   start   in   operation request, only looked at in IDLE
//   Funct3  in   operation select (MUL..REMU), latched on accept
//   SrcA    in   rs1 operand (multiplicand / dividend), latched on accept
//   SrcB    in   rs2 operand (multiplier / divisor), latched on accept
//   flush   in   kills the in-flight operation (ignored in DONE)
//   stall   out  pipeline hold request
//   busy    out  high in any state other than IDLE
//   done    out  one-cycle pulse, Result valid
//   Result  out  final result, held until the next done
//
// Build option:
//   MULDIV_EARLY_OUT_EN - when defined, a zero operand (either operand of a
//   multiply, or the divisor of a divide) skips the iteration loop. The
//   result values are identical in both builds.
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  flush,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIXUP,
        S_DONE
    } state_e;

    state_e           state_q,  state_d;
    logic [2:0]       op_q,     op_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic [W-1:0]     mag_a_q,  mag_a_d;
    logic [W-1:0]     mag_b_q,  mag_b_d;
    logic             sign_q,   sign_d;
    logic [2*W-1:0]   acc_q,    acc_d;
    logic [W-1:0]     rem_q,    rem_d;
    logic [W-1:0]     quo_q,    quo_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [W-1:0]     result_q, result_d;

    // Operand decode for the latched operation.
    logic is_div, a_signed, b_signed, neg_a, neg_b;
    assign is_div   = op_q[2];
    // Divides: bit 0 marks the unsigned forms. Multiplies: only MULHU treats
    // rs1 as unsigned, and MULHSU/MULHU both treat rs2 as unsigned.
    assign a_signed = is_div ? ~op_q[0] : (op_q[1:0] != 2'b11);
    assign b_signed = is_div ? ~op_q[0] : ~op_q[1];
    assign neg_a    = a_signed & a_q[W-1];
    assign neg_b    = b_signed & b_q[W-1];

    // The trial partial remainder is one bit wider than the operands. When
    // the trial is at least the divisor, the difference is smaller than the
    // divisor, so the low W bits of the subtraction are exact.
    logic [W:0] trial;
    assign trial = {rem_q, mag_a_q[cnt_q]};

    // Sign correction applied in FIXUP.
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;
    assign prod_fix = sign_q ? -acc_q : acc_q;
    assign quo_fix  = sign_q ? -quo_q : quo_q;
    assign rem_fix  = sign_q ? -rem_q : rem_q;

`ifdef MULDIV_EARLY_OUT_EN
    logic zero_op;
    assign zero_op = is_div ? (b_q == '0) : ((a_q == '0) || (b_q == '0));
`endif

    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no
        // path through the case statement can leave one unassigned (latch).
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        sign_d   = sign_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d    = Funct3;
                    a_d     = SrcA;
                    b_d     = SrcB;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                mag_a_d = neg_a ? -a_q : a_q;
                mag_b_d = neg_b ? -b_q : b_q;
                // The remainder takes the dividend's sign; everything else
                // takes the sign of the product/quotient.
                sign_d  = (is_div && op_q[1]) ? neg_a : (neg_a ^ neg_b);
                acc_d   = '0;
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = CW'(W - 1);
`ifdef MULDIV_EARLY_OUT_EN
                state_d = zero_op ? S_FIXUP : S_ITER;
`else
                state_d = S_ITER;
`endif
            end
            S_ITER: begin
                // Both loops walk the operand bits MSB first, using the
                // counter as the bit index.
                if (is_div) begin
                    if (trial >= {1'b0, mag_b_q}) begin
                        rem_d = trial[W-1:0] - mag_b_q;
                        quo_d = {quo_q[W-2:0], 1'b1};
                    end else begin
                        rem_d = trial[W-1:0];
                        quo_d = {quo_q[W-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {acc_q[2*W-2:0], 1'b0}
                          + (mag_b_q[cnt_q] ? {{W{1'b0}}, mag_a_q} : '0);
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_FIXUP;
            end
            S_FIXUP: begin
                if (is_div) begin
                    // Divide by zero bypasses the sign correction entirely.
                    if (b_q == '0) result_d = op_q[1] ? a_q : '1;
                    else           result_d = op_q[1] ? rem_fix : quo_fix;
                end else begin
                    result_d = (op_q[1:0] == 2'b00) ? prod_fix[W-1:0]
                                                    : prod_fix[2*W-1:W];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush cannot cancel a result that is already being presented.
        if (flush && (state_q != S_DONE)) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            sign_q   <= sign_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign stall  = ((state_q == S_IDLE) && start)
                  || (state_q == S_PREP) || (state_q == S_ITER)
                  || (state_q == S_FIXUP);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign Result = result_q;

endmodule
